hilo_mul_ctrl: RTL and testbench

Multi-cycle unsigned multiply controller and HI/LO owner for the EX stage of the 5-stage pipeline. It accepts `multu` operations, runs a shift-add multiplier over several cycles, and commits the 64-bit product into the HI/LO registers. It drives the 2-bit EX result-select code for the ALU/HI/LO/shifter result mux. It stalls the pipeline when an instruction needs HI/LO or the multiplier while a multiply is still in flight.

---
 rtl/hilo_mul_ctrl.sv | 85 ++++++++
 tb/tb_hilo_mul_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: multi-cycle shift-add multu engine owning HI/LO, with EX stall and result-mux select
module hilo_mul_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_mul,
  input  logic [1:0]  issue_class,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic [1:0]  mux_sel,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);
  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state_q, state_d;
  logic [63:0]    mcand_q, mcand_d, acc_q, acc_d, sum;
  logic [31:0]    mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d, accept;
  assign busy   = state_q == RUN;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  // hazard stall, result select, and the shift-add datapath step; HI/LO only change on the final step
  always_comb begin
    stall    = rst & issue_valid & busy & (issue_mul | issue_class == 2'b01 | issue_class == 2'b10);
    mux_sel  = (rst & issue_valid & ~issue_mul) ? issue_class : 2'b00;
    accept   = state_q == IDLE & issue_valid & issue_mul & ~stall;
    sum      = acc_q + mcand_q * 64'(mplier_q[BITS_PER_CYCLE-1:0]);
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (accept) begin
      state_d  = RUN;
      mcand_d  = {32'd0, src_a};
      mplier_d = src_b;
      acc_d    = 64'd0;
      cnt_d    = CW'(N - 1);
    end else if (state_q == RUN) begin
      acc_d    = sum;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        {hi_d, lo_d} = sum;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
    end
  end
  // state register; reset aborts any multiply in flight and clears HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// tb_hilo_mul_ctrl: randomized scoreboard bench for hilo_mul_ctrl against a cycle-count reference model
module tb_hilo_mul_ctrl;
  localparam int BPC = 1;
  localparam int N   = 32 / BPC;
  logic        clk, rst, issue_valid, issue_mul;
  logic [1:0]  issue_class, mux_sel;
  logic [31:0] src_a, src_b, hi_out, lo_out;
  logic        stall, busy, done;
  int          checks = 0, errors = 0;
  int          rem = 0;
  logic        done_exp = 1'b0;
  logic [63:0] mhl = 64'd0, pend = 64'd0;
  logic [63:0] q[$];

  hilo_mul_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_mul(issue_mul),
    .issue_class(issue_class), .src_a(src_a), .src_b(src_b), .stall(stall),
    .mux_sel(mux_sel), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must present the oldest outstanding product.
  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow done with no outstanding multiply at %0t", $time);
      end else begin
        chk("sb_product", {hi_out, lo_out}, q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic m, input logic [1:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    logic acc;
    @(negedge clk);
    chk("busy", busy, rem > 0);
    chk("done", done, done_exp);
    chk("hi", hi_out, mhl[63:32]);
    chk("lo", lo_out, mhl[31:0]);
    issue_valid = v; issue_mul = m; issue_class = c; src_a = a; src_b = b;
    #1;
    chk("stall", stall, v && rem > 0 && (m || c == 2'b01 || c == 2'b10));
    chk("mux_sel", mux_sel, (v && !m) ? c : 2'b00);
    acc = v && m && rem == 0;
    @(posedge clk);
    if (rem > 0) begin
      rem--;
      done_exp = rem == 0;
      if (rem == 0) mhl = pend;
    end else done_exp = 1'b0;
    if (acc) begin
      rem  = N;
      pend = 64'(a) * 64'(b);
      q.push_back(pend);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b1; issue_mul = $urandom_range(0, 1);
    issue_class = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    rem = 0; done_exp = 1'b0; mhl = 64'd0; q.delete();
    repeat (2) @(negedge clk);
    issue_valid = 1'b0; issue_mul = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_mul = 1'b0; issue_class = 2'b00;
    src_a = '0; src_b = '0;
    do_reset();
    idle(2);
    // max-value multiply
    step(1'b1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(N + 2);
    #1;
    chk("maxval_hi", hi_out, 32'hFFFFFFFE);
    chk("maxval_lo", lo_out, 32'h00000001);
    // mfhi hazard three cycles after the multiply
    step(1'b1, 1'b1, 2'b00, 32'h12345678, 32'h10);
    idle(2);
    for (int i = 0; i < N + 1; i++) step(1'b1, 1'b0, 2'b01, $urandom, $urandom);
    #1;
    chk("mfhi_hi", hi_out, 32'h00000001);
    chk("mfhi_lo", lo_out, 32'h23456780);
    // ALU and sll during RUN do not stall
    step(1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 32'h1234);
    step(1'b1, 1'b0, 2'b00, $urandom, $urandom);
    step(1'b1, 1'b0, 2'b11, $urandom, $urandom);
    step(1'b1, 1'b0, 2'b10, $urandom, $urandom);
    idle(N);
    // back-to-back: a second multu held while busy is taken in the done cycle
    step(1'b1, 1'b1, 2'b00, 32'hCAFEF00D, 32'h87654321);
    for (int i = 0; i < N + 1; i++) step(1'b1, 1'b1, 2'b00, 32'd7, 32'd6);
    idle(N + 2);
    #1;
    chk("b2b_hi", hi_out, 32'd0);
    chk("b2b_lo", lo_out, 32'd42);
    // reset in the middle of a run
    step(1'b1, 1'b1, 2'b00, $urandom, $urandom);
    idle((BPC == 4) ? 4 : 10);
    do_reset();
    idle(N + 4);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
           2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom);
    idle(N + 3);
    chk("sb_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
